// File: rtl/mem_access_stage_pkg.sv
// Shared encodings and lane helpers for the MEM stage: access sizes, FSM states,
// misalignment test, byte-enable generation and load extension.
package mem_access_stage_pkg;

  localparam logic [1:0] SZ_B = 2'b00;
  localparam logic [1:0] SZ_H = 2'b01;
  localparam logic [1:0] SZ_W = 2'b10;
  localparam int LAT_MAX = 15;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] off);
    case (size)
      SZ_B:    return 1'b0;
      SZ_H:    return off[0];
      default: return off != 2'b00;
    endcase
  endfunction

  function automatic logic [3:0] lane_mask(input logic [1:0] size, input logic [1:0] off);
    case (size)
      SZ_B:    return 4'b0001 << off;
      SZ_H:    return off[1] ? 4'b1100 : 4'b0011;
      default: return 4'b1111;
    endcase
  endfunction

  // Size code 11 falls into the word branch on purpose.
  function automatic logic [31:0] lane_extend(input logic [31:0] word, input logic [1:0] size,
                                              input logic [1:0] off, input logic uns);
    logic [7:0]  b;
    logic [15:0] h;
    b = word[8*off +: 8];
    h = off[1] ? word[31:16] : word[15:0];
    case (size)
      SZ_B:    return uns ? {24'b0, b} : {{24{b[7]}}, b};
      SZ_H:    return uns ? {16'b0, h} : {{16{h[15]}}, h};
      default: return word;
    endcase
  endfunction

endpackage

// File: rtl/mem_access_stage_dm_ram.sv
// Word-organised data RAM with per-byte write enables and a registered,
// enable-gated read port; only the read register is reset, never the array.
module dm_ram #(
  parameter int ADDR_W = 10
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              we,
  input  logic [3:0]        be,
  input  logic              re,
  input  logic [ADDR_W-1:0] addr,
  input  logic [31:0]       wdata,
  output logic [31:0]       rdata
);

  logic [31:0] mem [2**ADDR_W];

  always_ff @(posedge clk) begin
    for (int i = 0; i < 4; i++) begin
      if (we && be[i]) mem[addr][8*i +: 8] <= wdata[8*i +: 8];
    end
  end

  // Read register doubles as the stage's load-data register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)    rdata <= '0;
    else if (re) rdata <= mem[addr];
  end

endmodule

// File: rtl/mem_access_stage.sv
// MEM pipeline stage: multi-cycle data-memory access with pipeline stall,
// byte/half/word lanes, load extension and misalignment flagging.
module mem_access_stage
  import mem_access_stage_pkg::*;
#(
  parameter int ADDR_W = 10,
  parameter int LAT    = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              in_valid,
  input  logic [31:0]       in_alu,
  input  logic [31:0]       in_wdata,
  input  logic [4:0]        in_rd,
  input  logic              in_regw,
  input  logic              in_mem2r,
  input  logic              in_memr,
  input  logic              in_memw,
  input  logic [1:0]        in_size,
  input  logic              in_uns,
  output logic              stall,
  output logic [ADDR_W-1:0] DmAddr,
  output logic [31:0]       DmOut,
  output logic [31:0]       AluOut,
  output logic [4:0]        Rd,
  output logic              RegW,
  output logic              Mem2R,
  output logic              misalign
);

  state_t      state;
  logic [3:0]  cnt;
  logic        is_mem, is_store, is_load, mis, go;
  logic        rd_en, wr_en;
  logic [31:0] ld_word, wr_word;
  logic [3:0]  wr_be;

  assign is_mem   = in_valid & (in_memr | in_memw);
  assign is_store = in_memw;
  assign is_load  = in_memr & ~in_memw;
  assign mis      = is_misaligned(in_size, in_alu[1:0]);
  assign go       = is_mem & ~mis;

  // Counter holds the remaining WAIT cycles; leaving WAIT happens when it reaches one.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= ST_IDLE;
      cnt   <= '0;
    end else if (flush) begin
      state <= ST_IDLE;
      cnt   <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (go) begin
            if (LAT == 1) begin
              state <= ST_DONE;
              cnt   <= '0;
            end else begin
              state <= ST_WAIT;
              cnt   <= 4'(LAT - 1);
            end
          end
        end
        ST_WAIT: begin
          cnt <= cnt - 4'd1;
          if (cnt == 4'd1) state <= ST_DONE;
        end
        ST_DONE: state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign rd_en = go && is_load && !flush &&
                 ((state == ST_IDLE && LAT == 1) || (state == ST_WAIT && cnt == 4'd1));
  assign wr_en = go && is_store && !flush && state == ST_DONE;

  assign wr_be   = lane_mask(in_size, in_alu[1:0]);
  assign wr_word = (in_size == SZ_B) ? {4{in_wdata[7:0]}} :
                   (in_size == SZ_H) ? {2{in_wdata[15:0]}} : in_wdata;

  dm_ram #(.ADDR_W(ADDR_W)) u_ram (
    .clk   (clk),
    .rst   (rst),
    .we    (wr_en),
    .be    (wr_be),
    .re    (rd_en),
    .addr  (DmAddr),
    .wdata (wr_word),
    .rdata (ld_word)
  );

  // Stall is gated by reset so an in-flight request never holds the pipe during reset.
  assign stall    = rst && !flush && ((state == ST_IDLE && go) || state == ST_WAIT);
  assign DmAddr   = in_alu[ADDR_W+1:2];
  assign DmOut    = (state == ST_DONE && is_load) ?
                    lane_extend(ld_word, in_size, in_alu[1:0], in_uns) : '0;
  assign AluOut   = in_alu;
  assign Rd       = in_rd;
  assign Mem2R    = in_mem2r;
  assign RegW     = in_regw & in_valid & ~flush & ~(is_load & mis);
  assign misalign = is_mem & mis;

endmodule
